mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised load/store unit for the MEM stage of the 5-stage pipeline. It replaces the single-cycle store path with a handshaked data-memory interface that tolerates variable memory latency and handles the following:
- store-data forwarding from WB;
- lane-aligned store data and byte enables;
- load extraction and sign/zero extension;
- fault and timeout reporting.

While an access is in flight it back-pressures EX/MEM through `req_ready` and `stall`.

## Interface
Parameters:
- `XLEN`, 32, data width; legal values are 32 or 64. `NBE = XLEN/8`.
- `ALEN`, 32, address width.
- `TIMEOUT_CYCLES`, 64, maximum number of WAIT cycles before a load times out. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  EX/MEM presents an access.
- `req_ready`  out  1  unit can accept an access.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ALEN  byte address (ALU result).
- `req_wdata`  in  XLEN  store data (rs2 value).
- `req_funct3`  in  3  access type.
- `req_rs2`  in  5  store source register.
- `wb_reg_write`, `wb_rd`, `wb_write_data`  in  1/5/XLEN  WB write-back, used for forwarding.
- `dmem_req_valid`  out  1  memory request.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_addr`  out  ALEN  request address.
- `dmem_we`  out  1  request is a write.
- `dmem_wdata`  out  XLEN  lane-aligned write data.
- `dmem_be`  out  NBE  byte enables.
- `dmem_rsp_valid`  in  1  load data returned.
- `dmem_rdata`  in  XLEN  full-width read data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  XLEN  extended load result; 0 for stores and errors.
- `rsp_fault`  out  1  unsupported or misaligned access.
- `rsp_timeout`  out  1  load timed out.
- `stall`  out  1  pipeline hold.

## Operation
- States: IDLE, ISSUE, WAIT. `req_ready = (state == IDLE)` and `stall = (state != IDLE)`.
- **Capture (IDLE).** On `req_valid && req_ready`, register the address, we and funct3.
  - Store data: use `wb_write_data` when `wb_reg_write && wb_rd != 0 && wb_rd == req_rs2`; otherwise use `req_wdata`.
- **Lane and enables.** Let `off = addr[$clog2(NBE)-1:0]`.
  - Byte: data replicated to every byte lane, `be = 1 << off`.
  - Half: halfword replicated, `be = 2'b11 << off`.
  - Word: word replicated, `be = 4'hF << off`.
  - Double (XLEN=64 only): `be = 8'hFF`.
- **Legal funct3.**
  - Stores: 0, 1, 2, plus 3 when XLEN=64.
  - Loads: 0, 1, 2, 4, 5, plus 3 and 6 when XLEN=64.
  - Any other value is a fault: no memory request, return to IDLE, `rsp_valid = 1` and `rsp_fault = 1` next cycle.
- **ISSUE.** `dmem_req_valid = 1`, and the request fields are held stable until `dmem_req_ready`.
  - On handshake, a store returns to IDLE and pulses `rsp_valid` next cycle.
  - On handshake, a load moves to WAIT and clears the timeout counter.
- **WAIT.** `dmem_rsp_valid` is sampled only in WAIT.
  - On `dmem_rsp_valid`, shift `dmem_rdata` right by `off*8`, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD) into `rsp_rdata`, pulse `rsp_valid`, and return to IDLE.
  - The counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` (nonzero) with no response, pulse `rsp_valid` with `rsp_timeout = 1` and `rsp_rdata = 0`, and return to IDLE.
  - A late response after a timeout arrives in IDLE and is ignored.
- **Reset values.**
  - All outputs are 0, except `req_ready = 1`.
  - State is IDLE and the counter is 0.
  - Reset mid-access abandons the access: `dmem_req_valid` drops at that edge and no `rsp_valid` is produced.

## Timing
- Request accepted at edge 0: `dmem_req_valid` is high from cycle 1.
- Store with `dmem_req_ready` already high: handshake in cycle 1, `rsp_valid` in cycle 2, `req_ready` high again in cycle 2. Best-case throughput is one store per 2 cycles.
- Load: `dmem_rsp_valid` in cycle N gives `rsp_valid` in N+1.
- A new request may be accepted in the same cycle `rsp_valid` is high.
- `rsp_*` fields are valid only while `rsp_valid = 1`, and are registered.

## Configuration
- `MEM_LSU_MISALIGN_TRAP_EN`
  - Defined: an access whose address is not a multiple of its size is a fault. No memory request is made, and `rsp_fault` pulses one cycle after acceptance.
  - Undefined: no alignment check. Byte enables are the shifted masks truncated to NBE bits, load data is extracted by `off` shift, and memory handles the result.

## Test plan
- Forwarded store, XLEN=32.
  - Stimulus: SB to addr 0x103, `req_rs2 = 5`, `req_wdata = 0x11`, WB writes x5 = 0xA5.
  - Required: `dmem_wdata = 0xA5A5A5A5`, `dmem_be = 4'b1000`, `rsp_valid` 2 cycles after accept.
- Load sign-extension.
  - Stimulus: LH at 0x202, `dmem_rdata = 0x8001_1234`, response 3 cycles after the handshake.
  - Required: `rsp_rdata = 0xFFFF8001`. The LHU variant returns `0x00008001`.
- Back-pressure.
  - Stimulus: `dmem_req_ready` held low 5 cycles during a SW to 0x40, data 0xDEADBEEF.
  - Required: `dmem_addr`, `dmem_wdata` and `dmem_be = 4'hF` stable throughout, `stall` high throughout.
- Timeout.
  - Stimulus: `TIMEOUT_CYCLES = 4`, LW issued, no response.
  - Required: `rsp_timeout = 1` with `rsp_rdata = 0`. A response arriving 2 cycles later is ignored.
- Faults.
  - Stimulus: funct3 = 3 at XLEN=32; with the macro defined, LW at 0x101.
  - Required: `rsp_fault = 1` and `dmem_req_valid` never asserted.
- Reset during WAIT.
  - Stimulus: `rst_n` low one cycle while in WAIT.
  - Required: IDLE and `req_ready = 1` the next cycle, no `rsp_valid`.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a handshaked data-memory port.
// Optional build macro: MEM_LSU_MISALIGN_TRAP_EN (alignment faults).
// Handshake rule for both req_* and dmem_req_*: a transfer happens on a rising
// edge where valid and ready are both high; the sender holds all fields stable
// while valid is high and ready is low.
module mem_lsu #(
  parameter int XLEN           = 32,
  parameter int ALEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NBE            = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ALEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rs2,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [ALEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [NBE-1:0]  dmem_be,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic            rsp_timeout,
  output logic            stall
);

  localparam int OW = $clog2(NBE);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [ALEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NBE-1:0]    be_q, be_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dmem_req_valid_q, dmem_req_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic [XLEN-1:0]   st_data, lane_data;
  logic [NBE-1:0]    lane_be;
  logic [OW-1:0]     req_off;
  logic              legal, misalign;
  logic [63:0]       sh, ext;

  assign req_ready      = (state_q == S_IDLE);
  assign stall          = (state_q != S_IDLE);
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign req_off        = req_addr[OW-1:0];

  // Forward store data from WB, then replicate it into every lane and build enables.
  always_comb begin
    st_data = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == req_rs2)) ? wb_write_data : req_wdata;
    case (req_funct3[1:0])
      2'd0:    begin lane_data = {NBE{st_data[7:0]}};         lane_be = NBE'(1)  << req_off; end
      2'd1:    begin lane_data = {(NBE/2){st_data[15:0]}};    lane_be = NBE'(3)  << req_off; end
      2'd2:    begin lane_data = {(XLEN/32){st_data[31:0]}};  lane_be = NBE'(15) << req_off; end
      default: begin lane_data = st_data;                     lane_be = '1;                  end
    endcase
  end

  // Decide whether the presented funct3 is a supported access for this XLEN.
  always_comb begin
    if (req_we) begin
      legal = (req_funct3 <= 3'd2) || ((req_funct3 == 3'd3) && (XLEN == 64));
    end else begin
      legal = (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              ((req_funct3 inside {3'd3, 3'd6}) && (XLEN == 64));
    end
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  // An access whose address is not a multiple of its size traps.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Shift returned data down to the accessed lane and extend it per funct3.
  always_comb begin
    sh = 64'(dmem_rdata) >> {addr_q[OW-1:0], 3'b000};
    case (f3_q)
      3'd0:    ext = {{56{sh[7]}},  sh[7:0]};
      3'd1:    ext = {{48{sh[15]}}, sh[15:0]};
      3'd2:    ext = {{32{sh[31]}}, sh[31:0]};
      3'd4:    ext = {56'd0, sh[7:0]};
      3'd5:    ext = {48'd0, sh[15:0]};
      3'd6:    ext = {32'd0, sh[31:0]};
      default: ext = sh;
    endcase
  end

  // Next-state logic for the IDLE/ISSUE/WAIT access sequencer and its outputs.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    we_d             = we_q;
    f3_d             = f3_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    cnt_d            = cnt_q;
    dmem_req_valid_d = 1'b0;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = '0;
    rsp_fault_d      = 1'b0;
    rsp_timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = req_we ? lane_data : '0;
          be_d    = lane_be;
          if (!legal || misalign) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else begin
            state_d          = S_ISSUE;
            dmem_req_valid_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else begin
          dmem_req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = XLEN'(ext);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      we_q             <= 1'b0;
      f3_q             <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      cnt_q            <= '0;
      dmem_req_valid_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_fault_q      <= 1'b0;
      rsp_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      we_q             <= we_d;
      f3_q             <= f3_d;
      wdata_q          <= wdata_d;
      be_q             <= be_d;
      cnt_q            <= cnt_d;
      dmem_req_valid_q <= dmem_req_valid_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_fault_q      <= rsp_fault_d;
      rsp_timeout_q    <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu (XLEN=32, TIMEOUT_CYCLES=4)
// against a reference model built from the access rules.
module tb_mem_lsu;
  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rs2, wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_write_data;
  logic        dmem_req_ready, dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        req_ready, dmem_req_valid, dmem_we, rsp_valid, rsp_fault, rsp_timeout, stall;
  logic [31:0] dmem_addr, dmem_wdata, rsp_rdata;
  logic [3:0]  dmem_be;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  mem_lsu #(.XLEN(32), .ALEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .req_rs2(req_rs2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_timeout(rsp_timeout), .stall(stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: store lane data = low bytes of the data times a lane-replication constant.
  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF)   * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
    int bytes = 1 << f3[1:0];
    return 4'((((1 << bytes) - 1) << off) & 15);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] s = rd >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(s[15:0]));
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return s;
    endcase
  endfunction

  function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit f = we ? !(f3 <= 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    if ((a % (1 << f3[1:0])) != 0) f = 1'b1;
`else
    if (a[0] === 1'bx) f = 1'b1;
`endif
    return f;
  endfunction

  // Driver: starts at a negedge with the unit idle, ends at the negedge of rsp_valid.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input logic [4:0] rs2,
                           input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    logic [31:0] sd, ewd;
    logic [3:0]  ebe;
    bit          flt, tmo, done;
    int          off;
    off = int'(addr % 4);
    flt = ref_fault(we, f3, addr);
    sd  = (wbw && wbrd != 5'd0 && wbrd == rs2) ? wbd : wdata;
    ewd = ref_wdata(f3, sd);
    ebe = ref_be(f3, off);
    tmo = !we && !flt && (rsp_dly > TMO);
    exp_q.push_back((we || flt || tmo) ? 32'd0 : ref_load(f3, off, rdata));
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3;
    req_wdata = wdata; req_rs2 = rs2;
    wb_reg_write = wbw; wb_rd = wbrd; wb_write_data = wbd;
    @(posedge clk); #1;
    req_valid = 1'b0; wb_reg_write = 1'b0; req_wdata = $urandom;
    if (!flt) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        @(negedge clk);
        check_eq("issue_valid", dmem_req_valid, 1);
        check_eq("issue_stall", stall, 1);
        check_eq("issue_addr", dmem_addr, addr);
        check_eq("issue_we", dmem_we, we);
        check_eq("issue_be", dmem_be, ebe);
        if (we) check_eq("issue_wdata", dmem_wdata, ewd);
        if (i == rdy_dly) dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
      end
      if (!we) begin
        done = 1'b0;
        for (int k = 1; k <= TMO && !done; k++) begin
          @(negedge clk);
          check_eq("wait_no_rsp", rsp_valid, 0);
          check_eq("wait_stall", stall, 1);
          if (k == rsp_dly) begin
            dmem_rsp_valid = 1'b1; dmem_rdata = rdata; done = 1'b1;
          end
          @(posedge clk); #1;
          dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
        end
      end
    end
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_fault", rsp_fault, flt);
    check_eq("rsp_timeout", rsp_timeout, tmo);
    check_eq("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check_eq("rsp_req_ready", req_ready, 1);
    check_eq("rsp_no_dmem_req", dmem_req_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; req_rs2 = '0; wb_reg_write = 1'b0; wb_rd = '0; wb_write_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_dmem_valid", dmem_req_valid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_be", dmem_be, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    rst_n = 1'b1;

    // forwarded SB; LH / LHU sign handling; back-pressured SW
    do_access(1, 32'h103, 3'd0, 32'h11, 5'd5, 1, 5'd5, 32'hA5, 0, 0, 0);
    do_access(0, 32'h202, 3'd1, 0, 0, 0, 0, 0, 0, 3, 32'h8001_1234);
    do_access(0, 32'h202, 3'd5, 0, 0, 0, 0, 0, 0, 3, 32'h8001_1234);
    do_access(1, 32'h40, 3'd2, 32'hDEAD_BEEF, 5'd7, 1, 5'd0, 32'h1234, 5, 0, 0);
    do_access(0, 32'h80, 3'd2, 0, 0, 0, 0, 0, 1, TMO, 32'hCAFE_F00D);

    // timeout, then a late response that must be ignored
    do_access(0, 32'h44, 3'd2, 0, 0, 0, 0, 0, 0, TMO + 10, 32'h1111_2222);
    @(negedge clk);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("late_rsp_ignored", rsp_valid, 0);
    check_eq("late_rsp_idle", req_ready, 1);

    // unsupported funct3 and (when trapping) misalignment
    do_access(1, 32'h100, 3'd3, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    do_access(0, 32'h100, 3'd3, 0, 0, 0, 0, 0, 0, 1, 0);
    do_access(0, 32'h100, 3'd7, 0, 0, 0, 0, 0, 0, 1, 0);
    do_access(1, 32'h100, 3'd4, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    do_access(0, 32'h101, 3'd2, 0, 0, 0, 0, 0, 0, 1, 32'h8899_AABB);

    // reset while in WAIT
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_funct3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("prerst_stall", stall, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rstw_req_ready", req_ready, 1);
    check_eq("rstw_stall", stall, 0);
    check_eq("rstw_rsp_valid", rsp_valid, 0);
    check_eq("rstw_dmem_valid", dmem_req_valid, 0);
    rst_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("rstw_no_rsp", rsp_valid, 0);

    // randomized accesses
    for (int n = 0; n < 200; n++) begin
      logic [4:0] rs2 = 5'($urandom_range(0, 31));
      do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
                3'($urandom_range(0, 7)), $urandom, rs2,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? rs2 : 5'($urandom_range(0, 31)),
                $urandom, $urandom_range(0, 3), $urandom_range(1, TMO + 2), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
